tpu_v1: RTL and testbench



---
 rtl/tpu_pkg.sv | 28 ++
 rtl/systolic_array.sv | 83 ++++++++
 rtl/tpu_v1.sv | 177 +++++++++++++++++
 tb/tb_tpu_v1.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared widths, address map, element types and FSM state for the TPU v1 block.
package tpu_pkg;

    localparam int unsigned BITS_AB     = 8;
    localparam int unsigned BITS_C      = 16;
    localparam int unsigned DIM         = 8;
    localparam int unsigned ADDRW       = 16;
    localparam int unsigned DATAW       = 64;

    localparam int unsigned ROWW        = $clog2(DIM);
    localparam int unsigned HALF        = DIM / 2;
    localparam int unsigned BUSY_CYCLES = 3 * DIM - 1;
    localparam int unsigned CNTW        = $clog2(BUSY_CYCLES);
    localparam int unsigned BCNTW       = $clog2(DIM + 1);

    localparam logic [ADDRW-1:0] A_BASE     = 16'h0100;
    localparam logic [ADDRW-1:0] A_END      = 16'h0140;
    localparam logic [ADDRW-1:0] B_ADDR     = 16'h0200;
    localparam logic [ADDRW-1:0] C_BASE     = 16'h0300;
    localparam logic [ADDRW-1:0] C_END      = 16'h0380;
    localparam logic [ADDRW-1:0] START_ADDR = 16'h0400;

    typedef logic signed [BITS_AB-1:0] ab_t;
    typedef logic signed [BITS_C-1:0]  c_t;

    typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/systolic_array.sv
// Output-stationary DIM x DIM signed MAC grid: A flows right, B flows down,
// each PE accumulates into its own C entry (wrapping at BITS_C).
module systolic_array
    import tpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  ab_t             a_in    [DIM],
    input  ab_t             b_in    [DIM],
    input  logic            ld_en,
    input  logic [ROWW-1:0] ld_row,
    input  logic [DIM-1:0]  ld_mask,
    input  c_t              ld_data [DIM],
    output c_t              c_out   [DIM][DIM]
);

    ab_t a_r  [DIM][DIM-1];
    ab_t b_r  [DIM-1][DIM];
    ab_t a_w  [DIM][DIM];
    ab_t b_w  [DIM][DIM];
    c_t  prod [DIM][DIM];
    c_t  acc  [DIM][DIM];

    // Operand routing between neighbours and per-PE full-width signed product
    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_w[i][j] = a_in[i];
            end else begin : g_a_int
                assign a_w[i][j] = a_r[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_w[i][j] = b_in[j];
            end else begin : g_b_int
                assign b_w[i][j] = b_r[i-1][j];
            end
            assign prod[i][j]  = c_t'(a_w[i][j]) * c_t'(b_w[i][j]);
            assign c_out[i][j] = acc[i][j];
        end
    end

    // Operand pipeline registers; always flowing so idle zero feed flushes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM - 1; j++) begin
                    a_r[i][j] <= '0;
                    b_r[j][i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM - 1; j++) begin
                    a_r[i][j] <= a_w[i][j];
                    b_r[j][i] <= b_w[j][i];
                end
            end
        end
    end

    // Accumulators: MAC while enabled, otherwise masked host preload of one row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    acc[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    if (en) begin
                        acc[i][j] <= acc[i][j] + prod[i][j];
                    end else if (ld_en && ld_row == ROWW'(i) && ld_mask[j]) begin
                        acc[i][j] <= ld_data[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tpu_v1.sv
// TPU v1 top: MMIO decode, A row memory, B push buffer, run FSM, skewed feed
// into the systolic array, and the combinational C read mux.
module tpu_v1
    import tpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_w,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] dataIn,
    output logic [DATAW-1:0] dataOut,
    output logic             rdValid
);

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [BCNTW-1:0] b_cnt;

    ab_t a_mem   [DIM][DIM];
    ab_t b_buf   [DIM][DIM];
    ab_t in_row  [DIM];
    ab_t a_feed  [DIM];
    ab_t b_feed  [DIM];
    c_t  c_mat   [DIM][DIM];
    c_t  ld_data [DIM];
    logic [DIM-1:0] ld_mask;

    logic hit_a, hit_b, hit_c, hit_s;
    logic idle, busy, done;
    logic wr_a, wr_b, wr_c, start;
    logic [ROWW-1:0] a_row, c_row;
    logic c_half;

    assign hit_a  = (addr >= A_BASE) && (addr < A_END);
    assign hit_b  = (addr == B_ADDR);
    assign hit_c  = (addr >= C_BASE) && (addr < C_END);
    assign hit_s  = (addr == START_ADDR);
    assign a_row  = addr[ROWW+2:3];
    assign c_row  = addr[ROWW+3:4];
    assign c_half = addr[3];

    assign idle  = (state == IDLE);
    assign busy  = (state == BUSY);
    assign done  = busy && (cnt == CNTW'(BUSY_CYCLES - 1));
    assign start = idle && r_w && hit_s;
    assign wr_a  = idle && r_w && hit_a;
    assign wr_b  = idle && r_w && hit_b;
    assign wr_c  = idle && r_w && hit_c;

    // Split the write word into DIM byte lanes for A rows and B pushes
    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            in_row[k] = ab_t'(dataIn[BITS_AB*k +: BITS_AB]);
        end
    end

    // Run FSM: one start launches a fixed-length pass through the array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A row memory, written a whole row per access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                for (int k = 0; k < DIM; k++) begin
                    a_mem[i][k] <= '0;
                end
            end
        end else if (wr_a) begin
            for (int k = 0; k < DIM; k++) begin
                a_mem[a_row][k] <= in_row[k];
            end
        end
    end

    // B push buffer: fills rows in order, then slides so the last DIM pushes remain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cnt <= '0;
            for (int r = 0; r < DIM; r++) begin
                for (int k = 0; k < DIM; k++) begin
                    b_buf[r][k] <= '0;
                end
            end
        end else if (done) begin
            b_cnt <= '0;
        end else if (wr_b) begin
            if (b_cnt < BCNTW'(DIM)) begin
                for (int k = 0; k < DIM; k++) begin
                    b_buf[ROWW'(b_cnt)][k] <= in_row[k];
                end
                b_cnt <= b_cnt + BCNTW'(1);
            end else begin
                for (int r = 0; r < DIM - 1; r++) begin
                    for (int k = 0; k < DIM; k++) begin
                        b_buf[r][k] <= b_buf[r+1][k];
                    end
                end
                for (int k = 0; k < DIM; k++) begin
                    b_buf[DIM-1][k] <= in_row[k];
                end
            end
        end
    end

    // Skewed feed: row/column i sees element k = cnt - i, zero outside the window
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
        end
        if (busy) begin
            for (int i = 0; i < DIM; i++) begin
                if (cnt >= CNTW'(i) && cnt < CNTW'(i + DIM)) begin
                    a_feed[i] = a_mem[i][ROWW'(cnt - CNTW'(i))];
                    b_feed[i] = b_buf[ROWW'(cnt - CNTW'(i))][i];
                end
            end
        end
    end

    // C preload lanes: each half-row word carries HALF accumulators
    always_comb begin
        for (int j = 0; j < DIM; j++) begin
            ld_data[j] = c_t'(dataIn[BITS_C*(j % HALF) +: BITS_C]);
            ld_mask[j] = c_half ? (j >= HALF) : (j < HALF);
        end
    end

    systolic_array u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (busy),
        .a_in    (a_feed),
        .b_in    (b_feed),
        .ld_en   (wr_c),
        .ld_row  (c_row),
        .ld_mask (ld_mask),
        .ld_data (ld_data),
        .c_out   (c_mat)
    );

    // Combinational C read mux; everything else reads as zero/invalid
    always_comb begin
        dataOut = '0;
        rdValid = 1'b0;
        if (!r_w && hit_c) begin
            rdValid = 1'b1;
            for (int k = 0; k < HALF; k++) begin
                dataOut[BITS_C*k +: BITS_C] = c_mat[c_row][c_half ? ROWW'(k + HALF) : ROWW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_tpu_v1.sv
// Directed bench for tpu_v1: reset, C preload, identity, signed wrap,
// random matmul with busy-time noise, re-accumulate and mid-run reset.
module tb_tpu_v1;
    import tpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        r_w;
    logic [15:0] addr;
    logic [63:0] dataIn;
    logic [63:0] dataOut;
    logic        rdValid;

    int n_tests;
    int n_fail;

    logic signed [7:0] am [8][8];
    logic signed [7:0] bm [8][8];
    logic [15:0]       cm [8][8];
    logic [63:0]       bq [$];

    tpu_v1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .r_w     (r_w),
        .addr    (addr),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .rdValid (rdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        r_w = 1'b1; addr = a; dataIn = d;
        @(negedge clk);
        r_w = 1'b0; addr = 16'h0000; dataIn = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [63:0] exp, input logic exp_v);
        @(negedge clk);
        r_w = 1'b0; addr = a;
        #1;
        check(tag, dataOut, exp);
        check({tag, "_v"}, 64'(rdValid), 64'(exp_v));
    endtask

    function automatic logic [63:0] c_word(input int i, input int h);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) w[16*k +: 16] = cm[i][4*h+k];
        return w;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++)
            for (int h = 0; h < 2; h++)
                rd_chk($sformatf("%s_c%0d_%0d", tag, i, h), 16'h0300 + 16'(16*i + 8*h), c_word(i, h), 1'b1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                am[i][j] = '0; bm[i][j] = '0; cm[i][j] = '0;
            end
        bq.delete();
    endtask

    task automatic load_a();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = am[i][k];
            wr(16'h0100 + 16'(8*i), d);
        end
    endtask

    task automatic push_b(input logic [63:0] d);
        wr(16'h0200, d);
        bq.push_back(d);
    endtask

    task automatic zero_c();
        for (int w = 0; w < 16; w++) wr(16'h0300 + 16'(8*w), 64'h0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) cm[i][j] = '0;
    endtask

    // Golden: rows of B are the last 8 pushes (or the first n if fewer), C += A x B mod 2^16
    task automatic do_start();
        int n;
        int s;
        logic [63:0] d;
        n = bq.size();
        for (int r = 0; r < 8; r++) begin
            if (n >= 8 || r < n) begin
                d = (n >= 8) ? bq[n-8+r] : bq[r];
                for (int j = 0; j < 8; j++) bm[r][j] = d[8*j +: 8];
            end
        end
        bq.delete();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += int'(am[i][k]) * int'(bm[k][j]);
                cm[i][j] = cm[i][j] + 16'(s);
            end
        wr(16'h0400, 64'h0123_4567_89ab_cdef);
    endtask

    task automatic load_identity();
        logic [63:0] d;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) am[i][k] = (i == k) ? 8'sd1 : 8'sd0;
        load_a();
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(k*8 + j);
            push_b(d);
        end
    endtask

    initial begin
        logic [63:0] d;
        n_tests = 0;
        n_fail  = 0;
        r_w = 1'b0; addr = 16'h0000; dataIn = '0;
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_all("rst");

        // C half-row write and readback
        wr(16'h0310, 64'h0004_0003_0002_0001);
        wr(16'h0318, 64'h0008_0007_0006_0005);
        rd_chk("cwr_lo",   16'h0310, 64'h0004_0003_0002_0001, 1'b1);
        rd_chk("cwr_hi",   16'h0318, 64'h0008_0007_0006_0005, 1'b1);
        rd_chk("cwr_row0", 16'h0300, 64'h0, 1'b1);
        rd_chk("cwr_row2", 16'h0328, 64'h0, 1'b1);
        wr(16'h0310, 64'h0000_0000_0000_0009);
        rd_chk("cwr_keep", 16'h0318, 64'h0008_0007_0006_0005, 1'b1);
        rd_chk("cwr_new",  16'h0310, 64'h0000_0000_0000_0009, 1'b1);

        // Identity, read right at the latency bound
        zero_c();
        load_identity();
        do_start();
        repeat (BUSY_CYCLES) @(posedge clk);
        rd_chk("id_r0lo", 16'h0300, 64'h0003_0002_0001_0000, 1'b1);
        rd_chk("id_r7hi", 16'h0378, 64'h003F_003E_003D_003C, 1'b1);
        check_all("id");

        // Non-C reads
        rd_chk("rd_a",   16'h0100, 64'h0, 1'b0);
        rd_chk("rd_b",   16'h0200, 64'h0, 1'b0);
        rd_chk("rd_s",   16'h0400, 64'h0, 1'b0);
        rd_chk("rd_unm", 16'h0500, 64'h0, 1'b0);
        rd_chk("rd_cend", 16'h0380, 64'h0, 1'b0);

        // Signed extremes: 8 x 16384 wraps to 0
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) am[i][k] = -8'sd128;
        load_a();
        for (int k = 0; k < 8; k++) push_b(64'h8080_8080_8080_8080);
        zero_c();
        wr(16'h0300, 64'h0000_0000_0000_0005);
        cm[0][0] = 16'd5;
        do_start();
        repeat (30) @(posedge clk);
        rd_chk("sgn_c00", 16'h0300, 64'h0000_0000_0000_0005, 1'b1);
        check_all("sgn");

        // Random matmuls with ignored traffic during BUSY; second one over-pushes B
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < 8; k++) am[i][k] = 8'($urandom);
            load_a();
            for (int p = 0; p < 8 + 2*r; p++) begin
                d = {$urandom, $urandom};
                push_b(d);
            end
            zero_c();
            do_start();
            rd_chk($sformatf("busy_b%0d", r), 16'h0200, 64'h0, 1'b0);
            @(negedge clk); addr = 16'h0308; #1;
            check($sformatf("busy_cv%0d", r), 64'(rdValid), 64'd1);
            wr(16'h0300, 64'hFFFF_FFFF_FFFF_FFFF);
            wr(16'h0100, 64'h7F7F_7F7F_7F7F_7F7F);
            wr(16'h0200, 64'h0101_0101_0101_0101);
            wr(16'h0400, 64'h0);
            repeat (30) @(posedge clk);
            check_all($sformatf("rnd%0d", r));
        end

        // Second start with retained A/B/C accumulates again
        do_start();
        repeat (30) @(posedge clk);
        check_all("reacc");

        // Reset in the middle of a run, then a fresh run is accepted
        load_identity();
        do_start();
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("mrst");
        load_identity();
        do_start();
        repeat (30) @(posedge clk);
        rd_chk("post_r0lo", 16'h0300, 64'h0003_0002_0001_0000, 1'b1);
        check_all("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
